// File: rtl/mem_bus_arbiter_if.sv
// Fetch/data requester ports and the shared memory bus seen by mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        stall;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_ack, bus_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, if_ack, if_rdata, mem_ack, mem_rdata,
           bus_err, stall
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_ack, bus_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, if_ack, if_rdata, mem_ack, mem_rdata,
           bus_err, stall
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, alternating under
// contention, with a 255-cycle bus timeout. Grant to bus_req is one cycle; ack follows bus_ack by one.
module mem_bus_arbiter (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t     state;
  logic       last_grant_mem;
  logic [7:0] wait_cnt;
  logic       if_elig;
  logic       mem_elig;
  logic       grant_mem;
  logic       grant_if;
  logic       abort;

  // A requester whose ack is showing this cycle is still holding req for the old access.
  always_comb begin
    if_elig   = bus.if_req & ~bus.if_ack;
    mem_elig  = bus.mem_req & ~bus.mem_ack;
    grant_mem = mem_elig & (~if_elig | ~last_grant_mem);
    grant_if  = if_elig & ~grant_mem;
    abort     = ~bus.bus_ack & (wait_cnt == 8'd254);
  end

  assign bus.stall = (bus.mem_req & ~bus.mem_ack) | (bus.if_req & ~bus.if_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant_mem <= 1'b0;
      wait_cnt       <= 8'd0;
      bus.bus_req    <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= 32'h0000_0000;
      bus.bus_wdata  <= 32'h0000_0000;
      bus.if_ack     <= 1'b0;
      bus.if_rdata   <= 32'h0000_0000;
      bus.mem_ack    <= 1'b0;
      bus.mem_rdata  <= 32'h0000_0000;
      bus.bus_err    <= 1'b0;
    end else begin
      bus.if_ack  <= 1'b0;
      bus.mem_ack <= 1'b0;
      bus.bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state          <= BUSY_MEM;
            last_grant_mem <= 1'b1;
            wait_cnt       <= 8'd0;
            bus.bus_req    <= 1'b1;
            bus.bus_we     <= bus.mem_we;
            bus.bus_addr   <= bus.mem_addr;
            bus.bus_wdata  <= bus.mem_wdata;
          end else if (grant_if) begin
            state          <= BUSY_IF;
            last_grant_mem <= 1'b0;
            wait_cnt       <= 8'd0;
            bus.bus_req    <= 1'b1;
            bus.bus_we     <= 1'b0;
            bus.bus_addr   <= bus.if_addr;
            bus.bus_wdata  <= 32'h0000_0000;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (!bus.bus_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          // Timeout completes like a normal access but with zero data and an error pulse.
          if (bus.bus_ack || abort) begin
            state       <= IDLE;
            bus.bus_req <= 1'b0;
            bus.bus_err <= abort;
            if (state == BUSY_MEM) begin
              bus.mem_ack   <= 1'b1;
              bus.mem_rdata <= (bus.bus_ack && !bus.bus_we) ? bus.bus_rdata : 32'h0000_0000;
            end else begin
              bus.if_ack    <= 1'b1;
              bus.if_rdata  <= bus.bus_ack ? bus.bus_rdata : 32'h0000_0000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model compared every cycle,
// randomized requesters/memory, plus directed scenarios with hand-computed expectations.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_bus_arbiter_if bif ();
  mem_bus_arbiter dut (.clk(clk), .rst(rst), .bus(bif.slave));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, how long it has waited, and the outputs it must show.
  int          owner;      // 0 none, 1 fetch, 2 data
  bit          last_mem;
  int          waited;
  logic        e_bus_req, e_bus_we, e_if_ack, e_mem_ack, e_bus_err;
  logic [31:0] e_bus_addr, e_bus_wdata, e_if_rdata, e_mem_rdata;

  // Environment controls
  int          ack_mode = 0;  // 0 random, 1 never, 2 ack on busy cycle ack_at
  int          ack_at = 1;
  int          busy_seen = 0;
  logic [31:0] rd_fixed = 32'h0;
  bit          auto_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    owner = 0; last_mem = 1'b0; waited = 0;
    e_bus_req = 1'b0; e_bus_we = 1'b0; e_if_ack = 1'b0; e_mem_ack = 1'b0; e_bus_err = 1'b0;
    e_bus_addr = 32'h0; e_bus_wdata = 32'h0; e_if_rdata = 32'h0; e_mem_rdata = 32'h0;
  endfunction

  task automatic model_step();
    bit          ie, me;
    logic        n_if_ack, n_mem_ack, n_err;
    logic [31:0] data;
    if (rst) begin
      model_reset();
      return;
    end
    ie = bif.if_req && !e_if_ack;
    me = bif.mem_req && !e_mem_ack;
    n_if_ack = 1'b0; n_mem_ack = 1'b0; n_err = 1'b0;
    if (owner == 0) begin
      if (me && (!ie || !last_mem)) begin
        owner = 2; last_mem = 1'b1; waited = 0;
        e_bus_req = 1'b1; e_bus_we = bif.mem_we;
        e_bus_addr = bif.mem_addr; e_bus_wdata = bif.mem_wdata;
      end else if (ie) begin
        owner = 1; last_mem = 1'b0; waited = 0;
        e_bus_req = 1'b1; e_bus_we = 1'b0;
        e_bus_addr = bif.if_addr; e_bus_wdata = 32'h0;
      end
    end else begin
      waited++;
      if (bif.bus_ack || waited == 255) begin
        data = (bif.bus_ack && !e_bus_we) ? bif.bus_rdata : 32'h0;
        if (owner == 2) begin n_mem_ack = 1'b1; e_mem_rdata = data; end
        else begin n_if_ack = 1'b1; e_if_rdata = data; end
        n_err = !bif.bus_ack;
        owner = 0;
        e_bus_req = 1'b0;
      end
    end
    e_if_ack = n_if_ack; e_mem_ack = n_mem_ack; e_bus_err = n_err;
  endtask

  task automatic compare_all();
    chk("bus_req", 32'(bif.bus_req), 32'(e_bus_req));
    chk("bus_we", 32'(bif.bus_we), 32'(e_bus_we));
    chk("bus_addr", bif.bus_addr, e_bus_addr);
    chk("bus_wdata", bif.bus_wdata, e_bus_wdata);
    chk("if_ack", 32'(bif.if_ack), 32'(e_if_ack));
    chk("if_rdata", bif.if_rdata, e_if_rdata);
    chk("mem_ack", 32'(bif.mem_ack), 32'(e_mem_ack));
    chk("mem_rdata", bif.mem_rdata, e_mem_rdata);
    chk("bus_err", 32'(bif.bus_err), 32'(e_bus_err));
  endtask

  task automatic drive_env();
    if (bif.bus_req) busy_seen++; else busy_seen = 0;
    case (ack_mode)
      0: begin
        bif.bus_ack   = bif.bus_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        bif.bus_rdata = $urandom();
      end
      1: begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = $urandom();
      end
      default: begin
        bif.bus_ack   = (busy_seen == ack_at);
        bif.bus_rdata = rd_fixed;
      end
    endcase
    if (auto_en) begin
      if (bif.if_req) begin
        if (bif.if_ack) begin
          if ($urandom_range(0, 1) == 0) bif.if_addr = $urandom(); else bif.if_req = 1'b0;
        end else if ($urandom_range(0, 31) == 0) bif.if_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bif.if_req = 1'b1; bif.if_addr = $urandom();
      end
      if (bif.mem_req) begin
        if (bif.mem_ack) begin
          if ($urandom_range(0, 1) == 0) begin
            bif.mem_we = 1'($urandom_range(0, 1)); bif.mem_addr = $urandom(); bif.mem_wdata = $urandom();
          end else bif.mem_req = 1'b0;
        end else if ($urandom_range(0, 31) == 0) bif.mem_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bif.mem_req = 1'b1; bif.mem_we = 1'($urandom_range(0, 1));
        bif.mem_addr = $urandom(); bif.mem_wdata = $urandom();
      end
    end
  endtask

  // One clock: check stall late in the low phase, step the model on the rising edge,
  // compare registered outputs on the falling edge, then drive the next inputs.
  task automatic cycle();
    #2;
    chk("stall", 32'(bif.stall),
        32'((bif.mem_req & ~e_mem_ack) | (bif.if_req & ~e_if_ack)));
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive_env();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    auto_en = 1'b0;
    bif.if_req = 1'b0; bif.if_addr = 32'h0;
    bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.mem_addr = 32'h0; bif.mem_wdata = 32'h0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    int acks, ack_cyc, hold, stalls, busy, errs, ng;
    int grants[4];

    // Reset state
    do_reset();
    chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_bus_addr", bif.bus_addr, 32'h0);
    chk("rst_if_ack", 32'(bif.if_ack), 32'd0);
    chk("rst_mem_rdata", bif.mem_rdata, 32'h0);
    chk("rst_bus_err", 32'(bif.bus_err), 32'd0);

    // Fetch only, fastest memory
    ack_mode = 2; ack_at = 1; rd_fixed = 32'h3C011234;
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_0100;
    acks = 0; ack_cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (bif.bus_req) begin
        chk("if_bus_we", 32'(bif.bus_we), 32'd0);
        chk("if_bus_addr", bif.bus_addr, 32'h0000_0100);
      end
      if (bif.if_ack) begin
        acks++; ack_cyc = k;
        chk("if_rdata_val", bif.if_rdata, 32'h3C011234);
        bif.if_req = 1'b0;
      end
    end
    chk("if_ack_latency", 32'(ack_cyc), 32'd2);
    chk("if_ack_count", 32'(acks), 32'd1);

    // Store with three wait cycles
    do_reset();
    ack_mode = 2; ack_at = 4; rd_fixed = 32'h1234_5678;
    bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_addr = 32'h8000_0010; bif.mem_wdata = 32'hDEAD_BEEF;
    #1;
    stalls = bif.stall ? 1 : 0;
    hold = 0; acks = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (bif.bus_req && bif.bus_we && bif.bus_addr == 32'h8000_0010 && bif.bus_wdata == 32'hDEAD_BEEF)
        hold++;
      if (bif.mem_ack) begin
        acks++;
        chk("st_mem_rdata", bif.mem_rdata, 32'h0);
        chk("st_stall_ack_cycle", 32'(bif.stall), 32'd0);
        bif.mem_req = 1'b0;
      end else if (bif.stall) stalls++;
    end
    chk("st_hold_cycles", 32'(hold), 32'd4);
    chk("st_ack_count", 32'(acks), 32'd1);
    chk("st_stall_cycles", 32'(stalls), 32'd5);

    // Contention: both held, grants alternate starting with MEM
    do_reset();
    ack_mode = 2; ack_at = 2; rd_fixed = 32'h0BAD_F00D;
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_1000;
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h0000_2000;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      cycle();
      if (bif.bus_req && busy_seen == 1) begin
        grants[ng] = (bif.bus_addr == 32'h0000_2000) ? 2 : 1;
        ng++;
      end
    end
    chk("ct_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++)
      chk("ct_grant_order", 32'(grants[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
    bif.if_req = 1'b0; bif.mem_req = 1'b0;
    repeat (6) cycle();

    // Timeout with no bus_ack at all
    do_reset();
    ack_mode = 1;
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h0000_0400;
    busy = 0; acks = 0;
    for (int k = 0; k < 300 && acks == 0; k++) begin
      cycle();
      if (bif.bus_req) busy++;
      if (bif.mem_ack) begin
        acks++;
        chk("to_bus_err", 32'(bif.bus_err), 32'd1);
        chk("to_mem_rdata", bif.mem_rdata, 32'h0);
        chk("to_bus_req", 32'(bif.bus_req), 32'd0);
        bif.mem_req = 1'b0;
      end
    end
    chk("to_ack_seen", 32'(acks), 32'd1);
    chk("to_busy_cycles", 32'(busy), 32'd255);
    cycle();
    chk("to_err_one_cycle", 32'(bif.bus_err), 32'd0);

    // bus_ack on the last allowed busy cycle completes normally
    do_reset();
    ack_mode = 2; ack_at = 255; rd_fixed = 32'hA5A5_A5A5;
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h0000_0800;
    busy = 0; acks = 0; errs = 0;
    for (int k = 0; k < 300 && acks == 0; k++) begin
      cycle();
      if (bif.bus_req) busy++;
      if (bif.bus_err) errs++;
      if (bif.mem_ack) begin
        acks++;
        chk("to255_mem_rdata", bif.mem_rdata, 32'hA5A5_A5A5);
        bif.mem_req = 1'b0;
      end
    end
    chk("to255_ack_seen", 32'(acks), 32'd1);
    chk("to255_busy_cycles", 32'(busy), 32'd255);
    chk("to255_no_err", 32'(errs), 32'd0);

    // Asynchronous reset during a data access
    do_reset();
    ack_mode = 1;
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h0000_0040;
    repeat (3) cycle();
    chk("ar_busy_before", 32'(bif.bus_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_bus_req_async", 32'(bif.bus_req), 32'd0);
    chk("ar_bus_addr_async", bif.bus_addr, 32'h0);
    model_reset();
    bif.mem_req = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      cycle();
      if (bif.mem_ack) acks++;
    end
    chk("ar_no_ack_after_release", 32'(acks), 32'd0);
    ack_mode = 2; ack_at = 1; rd_fixed = 32'hCAFE_F00D;
    bif.mem_req = 1'b1; bif.mem_addr = 32'h0000_0044;
    ack_cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (bif.mem_ack && ack_cyc == 0) begin
        ack_cyc = k;
        chk("ar_next_rdata", bif.mem_rdata, 32'hCAFE_F00D);
        bif.mem_req = 1'b0;
      end
    end
    chk("ar_next_latency", 32'(ack_cyc), 32'd2);

    // Randomized traffic against the model
    do_reset();
    ack_mode = 0;
    auto_en = 1'b1;
    repeat (2000) cycle();
    auto_en = 1'b0;
    bif.if_req = 1'b0; bif.mem_req = 1'b0;
    repeat (300) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port if_req, input, 1 bit: fetch request, held by requester until if_ack.
REQ-004 SHALL have port if_addr, input, 32 bits: fetch word address.
REQ-005 SHALL have port mem_req, input, 1 bit: data request (MemRead|MemWrite of MEM stage), held until mem_ack.
REQ-006 SHALL have port mem_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port mem_addr, input, 32 bits: data address (MEM-stage alu_result).
REQ-008 SHALL have port mem_wdata, input, 32 bits: store data (MEM-stage rdata_b).
REQ-009 SHALL have port bus_ack, input, 1 bit: shared memory completes current access.
REQ-010 SHALL have port bus_rdata, input, 32 bits: read data, valid with bus_ack.
REQ-011 SHALL have ports bus_req (1), bus_we (1), bus_addr (32), bus_wdata (32), all outputs, all registered: shared memory request.
REQ-012 SHALL have ports if_ack (1), if_rdata (32), mem_ack (1), mem_rdata (32), all outputs, all registered.
REQ-013 SHALL have port bus_err, output, 1 bit: one-cycle timeout pulse.
REQ-014 SHALL have port stall, output, 1 bit: freeze pipeline registers.

Function
REQ-015 SHALL implement states IDLE, BUSY_IF, BUSY_MEM.
REQ-016 In IDLE, a requester is eligible when its req=1 and its ack output is 0 in that cycle; this blocks re-grant during the ack cycle.
REQ-017 In IDLE with only one eligible requester, SHALL grant it: state to BUSY_IF or BUSY_MEM, and bus_req=1 with latched addr/we/wdata from the next cycle.
REQ-018 In IDLE with both eligible, SHALL grant MEM unless last_grant_mem=1, in which case it SHALL grant IF.
REQ-019 last_grant_mem SHALL update on every grant: 1 for MEM, 0 for IF.
REQ-020 A fetch SHALL drive bus_we=0 and bus_wdata=0.
REQ-021 In BUSY_x, bus_* SHALL hold constant until bus_ack=1.
REQ-022 When bus_ack=1 is sampled in cycle M, the next cycle SHALL be IDLE with bus_req=0, x_ack=1 for exactly one cycle, and x_rdata=bus_rdata sampled in cycle M (0 for stores).
REQ-023 x_rdata SHALL hold its value until the next ack for that requester.
REQ-024 Minimum transaction latency: request at N, bus_req at N+1, ack at N+2 if bus_ack arrives at N+1.
REQ-025 Deassertion of x_req mid-transaction SHALL NOT abort the transaction; the ack still pulses.
REQ-026 bus_ack while IDLE SHALL be ignored.
REQ-027 An 8-bit wait counter SHALL clear on grant and increment each BUSY cycle without bus_ack.
REQ-028 At count 255 without bus_ack, the block SHALL abort: return to IDLE, bus_req=0, x_ack=1, x_rdata=0 and bus_err=1, each for one cycle.
REQ-029 bus_ack in the same cycle that count reaches 255 SHALL win: normal completion, no bus_err.
REQ-030 stall SHALL be combinational: (mem_req & ~mem_ack) | (if_req & ~if_ack).

Reset
REQ-031 While rst=1, immediately and regardless of clk, SHALL force state IDLE; bus_req, bus_we, if_ack, mem_ack, bus_err, last_grant_mem, and the counter to 0; and bus_addr, bus_wdata, if_rdata, mem_rdata to 32'h00000000.
REQ-032 Reset mid-transaction SHALL discard the transaction with no ack pulse; the first grant is possible in the first clk edge after rst falls.

Verification
REQ-033 IF only: if_req=1, if_addr=32'h00000100, bus_ack=1 at the cycle after bus_req rises, bus_rdata=32'h3C011234 -> if_ack pulses once with if_rdata=32'h3C011234; bus_we=0.
REQ-034 Store: mem_req=1, mem_we=1, mem_addr=32'h80000010, mem_wdata=32'hDEADBEEF, ack after 3 cycles -> bus_* hold those values for 4 cycles; mem_ack single pulse; mem_rdata=0.
REQ-035 Contention: both requests held continuously -> grants alternate MEM, IF, MEM, IF; no double grant during ack cycles.
REQ-036 Timeout: mem_req=1, bus_ack never -> after 255 busy cycles, mem_ack=1, bus_err=1, mem_rdata=0, state IDLE; variant with bus_ack at count 255 -> no bus_err.
REQ-037 Async reset: assert rst between clk edges during BUSY_MEM -> bus_req=0 immediately; no mem_ack after release; the next request is served normally.
REQ-038 Stall: mem_req=1 held across the transaction -> stall=1 every cycle until the mem_ack cycle, then 0.
